// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and helpers for the serial shift sequencer
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Counter width for a count range of 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// rtl/piso_shift.sv - parallel-in serial-out shift register with registered head bit
import shift_pkg::*;

module piso_shift #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  // Load wins over shift so a back-to-back reload on the last bit is never lost.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      if (MSB_FIRST != 0) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      else                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) shreg_q <= '0;
    else     shreg_q <= shreg_d;
  end

  assign sout = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - word handshake, bit/gap sequencing and framed serial output
import shift_pkg::*;

module shift_seq_ctrl #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          sout_q, sout_d;
  logic          sout_valid_q, sout_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_end_q, frame_end_d;
  logic          load, shift, head_bit, last_bit, accept;

  piso_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (in_data),
    .sout  (head_bit)
  );

  assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == BIT_LAST);
  assign in_ready = !rst && ((state_q == ST_IDLE) || (last_bit && (GAP == 0)));
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (!last_bit) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (GAP > 0) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else if (accept) begin
          load      = 1'b1;
          bit_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs lag the state by one cycle so bit k shows the edge after it is at the head.
  always_comb begin
    sout_d        = (state_q == ST_SHIFT) && head_bit;
    sout_valid_d  = (state_q == ST_SHIFT);
    frame_start_d = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
    frame_end_d   = last_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_valid, b_valid, c_valid;
  logic [7:0] a_data, b_data, c_data;
  logic       a_ready, a_sout, a_sv, a_fs, a_fe, a_busy;
  logic       b_ready, b_sout, b_sv, b_fs, b_fe, b_busy;
  logic       c_ready, c_sout, c_sv, c_fs, c_fe, c_busy;

  int tests = 0;
  int fails = 0;

  shift_seq_ctrl #(.WIDTH(8), .GAP(1), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .sout(a_sout), .sout_valid(a_sv), .frame_start(a_fs), .frame_end(a_fe), .busy(a_busy));

  shift_seq_ctrl #(.WIDTH(8), .GAP(1), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .sout(b_sout), .sout_valid(b_sv), .frame_start(b_fs), .frame_end(b_fe), .busy(b_busy));

  shift_seq_ctrl #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) u_b2b (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
    .sout(c_sout), .sout_valid(c_sv), .frame_start(c_fs), .frame_end(c_fe), .busy(c_busy));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat_a, pat_b;

  initial begin
    rst = 1'b1;
    a_valid = 0; b_valid = 0; c_valid = 0;
    a_data = '0; b_data = '0; c_data = '0;

    // Reset held for two cycles, then released
    tick();
    tick();
    chk("ready_in_reset", {7'd0, a_ready}, 8'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {7'd0, a_ready}, 8'd1);
    chk("busy_after_rst", {7'd0, a_busy}, 8'd0);
    chk("outs_after_rst", {4'd0, a_sout, a_sv, a_fs, a_fe}, 8'd0);
    chk("b2b_ready_after_rst", {7'd0, c_ready}, 8'd1);

    // Single word MSB-first (A5) and LSB-first (01) in parallel, with a dropped word mid-stream
    pat_a = 8'b1010_0101;
    pat_b = 8'b0000_0001;
    a_valid = 1; a_data = 8'hA5;
    b_valid = 1; b_data = 8'h01;
    tick();
    a_valid = 0; b_valid = 0;
    chk("busy_rise", {7'd0, a_busy}, 8'd1);
    chk("ready_drop", {7'd0, a_ready}, 8'd0);
    chk("no_valid_yet", {7'd0, a_sv}, 8'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("msb_sout%0d", k), {7'd0, a_sout}, {7'd0, pat_a[7-k]});
      chk($sformatf("msb_sv%0d", k), {7'd0, a_sv}, 8'd1);
      chk($sformatf("msb_fs%0d", k), {7'd0, a_fs}, {7'd0, k == 0});
      chk($sformatf("msb_fe%0d", k), {7'd0, a_fe}, {7'd0, k == 7});
      chk($sformatf("lsb_sout%0d", k), {7'd0, b_sout}, {7'd0, pat_b[k]});
      chk($sformatf("lsb_fe%0d", k), {7'd0, b_fe}, {7'd0, k == 7});
      if (k == 2) begin
        a_valid = 1; a_data = 8'h00;
        chk("bp_ready", {7'd0, a_ready}, 8'd0);
        chk("bp_busy", {7'd0, a_busy}, 8'd1);
      end
      if (k == 4) a_valid = 0;
    end
    chk("gap_ready", {7'd0, a_ready}, 8'd0);
    chk("gap_busy", {7'd0, a_busy}, 8'd1);
    tick();
    chk("post_gap_ready", {7'd0, a_ready}, 8'd1);
    chk("post_gap_busy", {7'd0, a_busy}, 8'd0);
    chk("post_gap_sv", {7'd0, a_sv}, 8'd0);
    chk("post_gap_fe", {7'd0, a_fe}, 8'd0);

    // Back-to-back FF then 00 with GAP=0
    c_valid = 1; c_data = 8'hFF;
    tick();
    c_data = 8'h00;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("b2b_sout%0d", k), {7'd0, c_sout}, {7'd0, k < 8});
      chk($sformatf("b2b_sv%0d", k), {7'd0, c_sv}, 8'd1);
      chk($sformatf("b2b_fs%0d", k), {7'd0, c_fs}, {7'd0, (k == 0) || (k == 8)});
      chk($sformatf("b2b_fe%0d", k), {7'd0, c_fe}, {7'd0, (k == 7) || (k == 15)});
      if (k == 6) chk("b2b_ready_last", {7'd0, c_ready}, 8'd1);
      if (k == 7) begin
        chk("b2b_ready_after", {7'd0, c_ready}, 8'd0);
        c_valid = 0;
      end
    end
    chk("b2b_idle_busy", {7'd0, c_busy}, 8'd0);
    tick();
    chk("b2b_idle_sv", {7'd0, c_sv}, 8'd0);

    // Mid-word reset on C3 after the third bit, then 81
    a_valid = 1; a_data = 8'hC3;
    tick();
    a_valid = 0;
    tick();
    tick();
    tick();
    chk("c3_bit2", {6'd0, a_sout, a_sv}, 8'b01);
    rst = 1'b1;
    #1;
    chk("rst_ready_low", {7'd0, a_ready}, 8'd0);
    tick();
    chk("abort_outs", {4'd0, a_sout, a_sv, a_fs, a_fe}, 8'd0);
    chk("abort_busy", {7'd0, a_busy}, 8'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready", {7'd0, a_ready}, 8'd1);
    pat_a = 8'h81;
    a_valid = 1; a_data = 8'h81;
    tick();
    a_valid = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("re_sout%0d", k), {7'd0, a_sout}, {7'd0, pat_a[7-k]});
      chk($sformatf("re_fs%0d", k), {7'd0, a_fs}, {7'd0, k == 0});
      chk($sformatf("re_fe%0d", k), {7'd0, a_fe}, {7'd0, k == 7});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for a serial shift datapath. It accepts parallel words over a valid/ready handshake, loads each word into an internal shift register, and shifts it out one bit per clock with frame markers. An optional idle gap separates consecutive words. It sits between a parallel word producer and any serial-in consumer, such as a SISO/SIPO shift chain or a serial link.

## Interface
- WIDTH, 8: bits per word; must be at least 2.
- GAP, 1: idle cycles inserted after each word; 0 means back-to-back words.
- MSB_FIRST, 1: 1 shifts in_data[WIDTH-1] first; 0 shifts in_data[0] first.

- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a word on in_data.
- in_data  input  WIDTH  parallel word to serialize.
- in_ready  output  1  controller can accept a word this cycle.
- sout  output  1  serial data bit, registered.
- sout_valid  output  1  sout carries a payload bit, registered.
- frame_start  output  1  first bit of a word is on sout, registered.
- frame_end  output  1  last bit of a word is on sout, registered.
- busy  output  1  state is not IDLE.

## Operation
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: in_ready=1. An accept (in_valid && in_ready at the clock edge) loads in_data into the shift register, clears the bit counter and moves to SHIFT.
  - SHIFT: one bit is output per cycle. The bit counter runs 0..WIDTH-1, with width $clog2(WIDTH).
    - At count WIDTH-1 with GAP>0, go to GAP.
    - At count WIDTH-1 with GAP=0: if an accept occurs, reload and stay in SHIFT with the counter at 0; otherwise go to IDLE.
  - GAP: the gap counter runs 0..GAP-1. At GAP-1, go to IDLE.
- in_ready = !rst && (state==IDLE || (state==SHIFT && last bit && GAP==0)).
  - in_ready is combinational from state only and never depends on in_valid.
- in_valid without in_ready is ignored. in_data is sampled only on an accept.
- Outputs outside SHIFT: sout=0, sout_valid=0, frame_start=0, frame_end=0.
- Reset (any state, including mid-word):
  - State becomes IDLE; counters and shift register are cleared.
  - All registered outputs are 0 in the cycle after the reset edge.
  - An aborted word produces no frame_end.
  - in_ready is 0 while rst is high.

## Timing
- Accept at edge N: bit 0 appears at edge N+1, with sout_valid=1 and frame_start=1.
- Bit k appears at edge N+1+k. The last bit appears at edge N+WIDTH, with frame_end=1.
- Latency from accept to first bit is 1 cycle. A word occupies WIDTH cycles.
- Minimum word period is WIDTH+GAP cycles:
  - GAP>0: the earliest next accept is the cycle after the gap ends.
  - GAP=0: throughput is 100%. sout_valid stays high across words, and frame_end of word A coincides with the cycle before frame_start of word B.
- When WIDTH=1 is not supported, frame_start and frame_end never coincide.
- busy rises the cycle after an accept and falls the cycle the state returns to IDLE.

## Structure
- Shared package shift_pkg holds:
  - the state enum typedef (IDLE, SHIFT, GAP);
  - a localparam helper for counter width.
- Sub-module piso_shift (WIDTH, MSB_FIRST), which holds the shift register:
  - ports: clk, rst, load, shift, din[WIDTH], sout;
  - output is the registered head bit.
- shift_seq_ctrl holds the FSM, the bit and gap counters, the handshake and the frame flags.

## Test plan
- Reset release, WIDTH=8: rst held high for 2 cycles, then low -> all outputs 0; in_ready=1 the first cycle after release; busy=0.
- Single word, MSB_FIRST=1, GAP=1: in_data=8'hA5 accepted -> sout 1,0,1,0,0,1,0,1 over 8 consecutive cycles; frame_start on the first, frame_end on the eighth; 1 gap cycle, then in_ready=1.
- LSB-first: MSB_FIRST=0, in_data=8'h01 -> sout 1,0,0,0,0,0,0,0.
- Back-to-back, GAP=0: in_valid held high with 8'hFF then 8'h00 -> 16 contiguous sout_valid cycles; second accept on the first word's last-bit cycle; sout 8 ones then 8 zeros.
- Backpressure: in_valid pulsed during SHIFT with in_ready=0 -> word dropped, no change to the output stream; busy stays 1.
- Mid-word reset: rst asserted after the 3rd bit of 8'hC3 -> the next cycle has sout_valid=0, no frame_end, state IDLE; a new word 8'h81 after release serializes correctly.
